fp24_to_fixed: RTL and testbench
================================

Name: fp24_to_fixed

Overview:
- Pipelined converter from the team's 24-bit float (fp24) to signed two's-complement fixed point. It is the decode direction that pairs with the fp24 arithmetic units.
- fp24 layout: {sign[23], exp[22:16], mant[15:0]}, exponent bias 63, implicit leading one. exp==0 encodes zero; mant is ignored in that case.
- Feeds fixed-point consumers such as pixel/coordinate logic and DSP paths. Uses a valid/ready stream on both sides with full-pipeline stall.

Parameters:
- INT_BITS, 16, integer bits of the output, including sign.
- FRAC_BITS, 16, fractional bits of the output. Must be >= 1. Output width W = INT_BITS+FRAC_BITS.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  a is valid this cycle
- in_ready  output  1  block accepts a this cycle
- a  input  24 (fp24)  operand
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- fixed  output  W  signed result, Q(INT_BITS-1).FRAC_BITS
- ovf  output  1  result saturated
- udf  output  1  nonzero input converted to 0

Behaviour:
- Value = (-1)^sign * {1,mant}/2^16 * 2^(exp-63). Output = that value * 2^FRAC_BITS, truncated toward zero (magnitude truncation, then negate).
- Two register stages; latency is exactly 2 cycles from an accepted input to out_valid when there is no stall.
- Stage 1 (registered): sign, 17-bit mag={1,mant}, signed shift s = exp-63+FRAC_BITS-16 (9-bit signed), is_zero = (exp==0), pre_ovf = (exp-63 >= INT_BITS-1).
- Stage 2 (registered), in priority order:
  - If is_zero: fixed=0, ovf=0, udf=0.
  - Else if pre_ovf: fixed = 2^(W-1)-1 for positive input, or -2^(W-1) for negative input; ovf=1.
  - Else: m = s>=0 ? mag<<s : mag>>(-s), computed in a W+17-bit intermediate. fixed = sign ? -m : m. udf = (m==0).
- Shifts with |s| >= 17 on the right side give m=0. Shift width must never truncate before the saturation check.
- Handshake:
  - Global enable en = !out_valid || out_ready. in_ready = en.
  - An input transfers when in_valid && in_ready.
  - When en=1, all stages advance and valid bits shift. Bubbles propagate as valid=0.
  - When en=0, all stage registers and outputs hold. fixed/ovf/udf stay stable while out_valid && !out_ready.
  - Simultaneous output pop and input accept in the same cycle is legal and gives full throughput, 1 result per cycle.
- Reset: out_valid=0, stage-1 valid=0, fixed=0, ovf=0, udf=0. in_ready is 1 in the cycle after reset.
  - Reset mid-operation discards all in-flight items. No spurious out_valid after reset.
- ovf and udf are only meaningful when out_valid=1. They are never both 1.

Optional Feature:
- Macro: FP24_TO_FIXED_ROUND_EN.
- Defined: magnitude rounds to nearest, ties away from zero, before negation. The rounding bit is the first bit shifted out when s<0.
  - Rounding carry into 2^(INT_BITS-1) saturates and sets ovf=1.
  - udf=1 only if the rounded magnitude is 0.
- Undefined: truncation toward zero as above. Latency is unchanged either way.

Test Plan:
- Basic, INT_BITS=FRAC_BITS=16, out_ready=1:
  - a=0x3F0000 (1.0) -> fixed=0x00010000, 2 cycles later.
  - a=0xC04000 (-2.5) -> fixed=0xFFFD8000.
  - a=0x000000 and a=0x80ABCD -> fixed=0, ovf=0, udf=0.
- Saturation:
  - a=0x4DFFFF -> fixed=0x7FFFC000, ovf=0.
  - a=0x4E0000 -> fixed=0x7FFFFFFF, ovf=1.
  - a=0xCE0000 -> fixed=0x80000000, ovf=1.
- Underflow boundary:
  - a=0x2F0000 (2^-16) -> fixed=0x00000001, udf=0.
  - a=0x2E0000 (2^-17) -> fixed=0, udf=1.
  - With FP24_TO_FIXED_ROUND_EN: a=0x2E0000 -> fixed=0x00000001, udf=0.
- Back-to-back stream: 8 consecutive valid inputs with out_ready=1 -> 8 consecutive out_valid cycles, in order, values matching the reference model.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 once the output is valid, output value stable, no loss or duplication. Release -> remaining items emerge in order.
- Reset mid-stream: assert rst for 1 cycle with 2 items in flight -> out_valid=0 the next cycle and no stale output ever appears. A new input yields the correct result after 2 cycles.

Source files
------------

// File: rtl/fp24_to_fixed.sv
// fp24 {sign, exp(bias 63), mant16} to signed Q(INT_BITS-1).FRAC_BITS, two-stage valid/ready pipeline.
// Optional macro FP24_TO_FIXED_ROUND_EN: round-to-nearest (ties away from zero) instead of truncation.
module fp24_to_fixed #(
  parameter int INT_BITS  = 16,
  parameter int FRAC_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [23:0]                   a,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT_BITS+FRAC_BITS-1:0] fixed,
  output logic                          ovf,
  output logic                          udf
);

  localparam int W  = INT_BITS + FRAC_BITS;
  localparam int WX = W + 17;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: unpack and precompute shift / range flags
  logic signed [9:0] e_unb;
  logic signed [9:0] s_wide;
  logic              zero_next;
  logic              pre_ovf_next;

  assign e_unb        = $signed({3'b000, a[22:16]}) - 10'sd63;
  assign s_wide       = e_unb + 10'(FRAC_BITS - 16);
  assign zero_next    = (a[22:16] == 7'd0);
  assign pre_ovf_next = (e_unb >= 10'(INT_BITS - 1));

  logic              v1_reg;
  logic              sign1_reg;
  logic [16:0]       mag1_reg;
  logic signed [8:0] s1_reg;
  logic              zero1_reg;
  logic              pov1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      sign1_reg <= 1'b0;
      mag1_reg  <= '0;
      s1_reg    <= '0;
      zero1_reg <= 1'b0;
      pov1_reg  <= 1'b0;
    end else if (en) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        sign1_reg <= a[23];
        mag1_reg  <= {1'b1, a[15:0]};
        s1_reg    <= s_wide[8:0];
        zero1_reg <= zero_next;
        pov1_reg  <= pre_ovf_next;
      end
    end
  end

  // Stage 2: shift in a wide intermediate so nothing is lost before the range check
  logic [WX-1:0] mag_ext;
  logic [8:0]    rsh;
  logic [WX-1:0] m_trunc;
  logic [WX-1:0] m_final;

  assign mag_ext = {{W{1'b0}}, mag1_reg};
  assign rsh     = -s1_reg;

  always_comb begin
    m_trunc = '0;
    if (!s1_reg[8]) begin
      m_trunc = mag_ext << s1_reg[7:0];
    end else begin
      m_trunc = mag_ext >> rsh;
    end
  end

`ifdef FP24_TO_FIXED_ROUND_EN
  // Round bit is the first bit shifted out; zero when shifting left.
  logic [17:0] rnd_src;
  logic        rnd_bit;

  always_comb begin
    rnd_src = '0;
    if (s1_reg[8]) begin
      rnd_src = {mag1_reg, 1'b0} >> rsh;
    end
    rnd_bit = rnd_src[0];
  end

  assign m_final = m_trunc + {{(WX-1){1'b0}}, rnd_bit};
`else
  assign m_final = m_trunc;
`endif

  logic          mag_sat;
  logic [W-1:0]  mag_w;
  logic [W-1:0]  fixed_next;
  logic          ovf_next;
  logic          udf_next;

  assign mag_sat = |m_final[WX-1:W-1];
  assign mag_w   = m_final[W-1:0];

  always_comb begin
    fixed_next = '0;
    ovf_next   = 1'b0;
    udf_next   = 1'b0;
    if (zero1_reg) begin
      fixed_next = '0;
    end else if (pov1_reg || mag_sat) begin
      fixed_next = sign1_reg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      ovf_next   = 1'b1;
    end else begin
      fixed_next = sign1_reg ? -mag_w : mag_w;
      udf_next   = (mag_w == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      fixed     <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else if (en) begin
      out_valid <= v1_reg;
      if (v1_reg) begin
        fixed <= fixed_next;
        ovf   <= ovf_next;
        udf   <= udf_next;
      end
    end
  end

endmodule

// File: tb/tb_fp24_to_fixed.sv
// Scoreboard bench for fp24_to_fixed: driver pushes expectations, negedge monitor pops and compares.
module tb_fp24_to_fixed;

  localparam int INT_BITS  = 16;
  localparam int FRAC_BITS = 16;
  localparam int W         = INT_BITS + FRAC_BITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [23:0]  a;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] fixed;
  logic         ovf;
  logic         udf;

  always #5 clk = ~clk;

  fp24_to_fixed #(.INT_BITS(INT_BITS), .FRAC_BITS(FRAC_BITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .fixed(fixed), .ovf(ovf), .udf(udf)
  );

  typedef struct packed {
    logic [23:0]  a;
    logic [W-1:0] fx;
    logic         ov;
    logic         uf;
  } vec_t;

  typedef struct {
    vec_t v;
    bit   chk_lat;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Present one item starting just after a negedge; returns on the negedge after acceptance.
  task automatic send(input vec_t v, input bit lat);
    exp_t e;
    int   g;
    in_valid = 1'b1;
    a        = v.a;
    #1;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 200) begin
      n_checks++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for a=%h", v.a);
    end else begin
      e.v = v; e.chk_lat = lat; e.cyc = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: compares each transferred result and checks outputs hold while stalled
  initial begin
    exp_t           e;
    logic [W+2:0]   held;
    bit             held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held_v = 1'b0;
        continue;
      end
      if (held_v) check("stall_hold", 64'({out_valid, fixed, ovf, udf}), 64'(held));
      held_v = 1'b0;
      if (out_valid && !out_ready) begin
        held_v = 1'b1;
        held   = {out_valid, fixed, ovf, udf};
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_output: got fixed=%h with no pending item, expected none", fixed);
        end else begin
          e = q.pop_front();
          check("result", 64'({fixed, ovf, udf}), 64'({e.v.fx, e.v.ov, e.v.uf}));
          if (e.chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
          $display("txn a=%h fixed=%h ovf=%b udf=%b", e.v.a, fixed, ovf, udf);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t basic[12];
  vec_t stream[8];
  vec_t bp[4];

  initial begin
    basic = '{
      '{24'h3F0000, 32'h00010000, 1'b0, 1'b0},
      '{24'hC04000, 32'hFFFD8000, 1'b0, 1'b0},
      '{24'h000000, 32'h00000000, 1'b0, 1'b0},
      '{24'h80ABCD, 32'h00000000, 1'b0, 1'b0},
      '{24'h4DFFFF, 32'h7FFFC000, 1'b0, 1'b0},
      '{24'h4E0000, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{24'hCE0000, 32'h80000000, 1'b1, 1'b0},
      '{24'h2F0000, 32'h00000001, 1'b0, 1'b0},
      '{24'h2E0000, 32'h00000000, 1'b0, 1'b1},
      '{24'h7F0000, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{24'h01FFFF, 32'h00000000, 1'b0, 1'b1},
      '{24'hAF0000, 32'hFFFFFFFF, 1'b0, 1'b0}
    };
`ifdef FP24_TO_FIXED_ROUND_EN
    basic[8].fx = 32'h00000001;
    basic[8].uf = 1'b0;
`endif
    stream = '{
      '{24'h3E0000, 32'h00008000, 1'b0, 1'b0},
      '{24'hBF0000, 32'hFFFF0000, 1'b0, 1'b0},
      '{24'h3F8000, 32'h00018000, 1'b0, 1'b0},
      '{24'h460000, 32'h00800000, 1'b0, 1'b0},
      '{24'hCD0000, 32'hC0000000, 1'b0, 1'b0},
      '{24'h310001, 32'h00000004, 1'b0, 1'b0},
      '{24'h2DFFFF, 32'h00000000, 1'b0, 1'b1},
      '{24'hFF0000, 32'h80000000, 1'b1, 1'b0}
    };
    bp = '{
      '{24'h400000, 32'h00020000, 1'b0, 1'b0},
      '{24'hC00000, 32'hFFFE0000, 1'b0, 1'b0},
      '{24'h3D0000, 32'h00004000, 1'b0, 1'b0},
      '{24'h4C0000, 32'h20000000, 1'b0, 1'b0}
    };

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_fixed", 64'(fixed), 64'd0);
    check("reset_flags", 64'({ovf, udf}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed vectors, one idle cycle between items
    foreach (basic[i]) begin
      send(basic[i], 1'b1);
      @(negedge clk);
    end
    drain();

    // Back-to-back stream: latency of 2 on every item implies one result per cycle
    foreach (stream[i]) send(stream[i], 1'b1);
    drain();

    // Backpressure: stall the output for 5 cycles while inputs keep coming
    fork
      begin
        foreach (bp[i]) send(bp[i], 1'b0);
      end
      begin
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
      end
    join
    drain();

    // Reset with two items in flight; they must never appear
    out_ready = 1'b0;
    send(basic[0], 1'b0);
    send(bp[0], 1'b0);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_flush_out_valid", 64'(out_valid), 64'd0);
    repeat (4) @(negedge clk);
    send('{24'hC08000, 32'hFFFD0000, 1'b0, 1'b0}, 1'b1);
    drain();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
